// File: rtl/tpu_cmd_issuer.sv
// Buffers host instruction words and streams them to the tpu on start (one pop per cycle,
// 1-cycle pop-to-instruction latency); in_ready drops when full; read results return READ_LAT+1 cycles after issue.
module tpu_cmd_issuer #(
  parameter int         DEPTH       = 8,
  parameter logic [1:0] READ_OPCODE = 2'b11,
  parameter int         READ_LAT    = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [15:0]                in_instr,
  input  logic                       start,
  output logic [15:0]                instruction,
  input  logic [7:0]                 result,
  output logic                       res_valid,
  output logic [7:0]                 res_data,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [15:0]           r_mem [DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic [15:0]           r_instr;
  logic [READ_LAT-1:0]   r_rd;
  logic                  r_res_vld;
  logic [7:0]            r_res_dat;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_issue_rd;
  logic                  w_busy;

  assign in_ready   = (r_count != CW'(DEPTH));
  assign w_push     = in_valid && in_ready;
  assign w_issue_rd = (r_instr[15:14] == READ_OPCODE);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= in_instr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && (r_count != '0)) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if ((r_count == '0) || (w_pop && !w_push && (r_count == CW'(1)))) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The last issued word may itself be a read that is not yet in the tracker.
        if ((r_rd == '0) && !w_issue_rd) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop  = 1'b0;
    w_busy = 1'b0;
    case (r_state)
      S_RUN: begin
        w_pop  = (r_count != '0);
        w_busy = 1'b1;
      end
      S_DRAIN: begin
        w_busy = 1'b1;
      end
      default: begin
        w_pop  = 1'b0;
        w_busy = 1'b0;
      end
    endcase
  end

  // Tracker bit k set means a read issued k+1 cycles ago; MSB lines up with result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr   <= '0;
      r_rd      <= '0;
      r_res_vld <= 1'b0;
      r_res_dat <= '0;
    end else begin
      r_instr   <= w_pop ? r_mem[r_rptr] : 16'h0000;
      r_rd      <= (r_rd << 1) | READ_LAT'(w_issue_rd);
      r_res_vld <= r_rd[READ_LAT-1];
      if (r_rd[READ_LAT-1]) begin
        r_res_dat <= result;
      end
    end
  end

  assign instruction = r_instr;
  assign res_valid   = r_res_vld;
  assign res_data    = r_res_dat;
  assign busy        = w_busy;
  assign fifo_count  = r_count;

endmodule

// File: tb/tb_tpu_cmd_issuer.sv
// Randomized and directed bench for tpu_cmd_issuer with a queue-based reference model and scoreboards.
module tb_tpu_cmd_issuer;

  localparam int DEPTH = 8;
  localparam int LAT   = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [15:0]   in_instr = 16'h0000;
  logic          start = 1'b0;
  logic [15:0]   instruction;
  logic [7:0]    result = 8'h00;
  logic          res_valid;
  logic [7:0]    res_data;
  logic          busy;
  logic [CW-1:0] fifo_count;

  tpu_cmd_issuer #(.DEPTH(DEPTH), .READ_OPCODE(2'b11), .READ_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .start(start), .instruction(instruction), .result(result),
    .res_valid(res_valid), .res_data(res_data),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: program queue, run flag, and whether a word is expected on the bus.
  logic [15:0] mq[$];
  logic [15:0] sb_instr[$];
  logic [7:0]  sb_res[$];
  bit          mrun   = 1'b0;
  bit          missue = 1'b0;

  int          cyc = 0;
  bit          tv [8];
  logic [7:0]  tdat [8];
  int          t_idx;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [7:0] byte_of(input logic [15:0] w);
    if (w == 16'hC005) return 8'hA5;
    if (w == 16'hC006) return 8'h5A;
    return w[7:0] ^ w[15:8];
  endfunction

  function automatic logic [15:0] rnd_word();
    logic [15:0] w;
    w = 16'($urandom);
    if (w == 16'h0000) w = 16'h0001;
    return w;
  endfunction

  task automatic tick(input logic v, input logic [15:0] w, input logic s);
    int  pre;
    bit  acc;
    bit  pop;
    in_valid = v;
    in_instr = w;
    start    = s;
    @(posedge clk);
    pre = mq.size();
    acc = v && (pre != DEPTH);
    pop = mrun && (pre > 0);
    if (pop) void'(mq.pop_front());
    if (acc) begin
      mq.push_back(w);
      sb_instr.push_back(w);
      if (w[15:14] == 2'b11) sb_res.push_back(byte_of(w));
    end
    if (!mrun && s && pre > 0) mrun = 1'b1;
    else if (mrun && pop && !acc && pre == 1) mrun = 1'b0;
    missue = pop;
    #1;
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit rnd);
    int k;
    k = 0;
    tick(1'b0, 16'h0000, 1'b0);
    while (busy && k < budget) begin
      if (rnd) tick(1'($urandom_range(0, 1)), rnd_word(), mrun ? 1'($urandom_range(0, 1)) : 1'b0);
      else     tick(1'b0, 16'h0000, 1'b0);
      k++;
    end
    if (busy) begin
      n_chk++;
      $display("FAIL idle_timeout: busy still %0b after %0d cycles", busy, budget);
    end
  endtask

  task automatic clear_model();
    mq.delete();
    sb_instr.delete();
    sb_res.delete();
    mrun   = 1'b0;
    missue = 1'b0;
    for (int i = 0; i < 8; i++) tv[i] = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_instruction"}, 32'(instruction), 32'h0);
    check({tag, "_res_valid"},   32'(res_valid),   32'h0);
    check({tag, "_res_data"},    32'(res_data),    32'h0);
    check({tag, "_busy"},        32'(busy),        32'h0);
    check({tag, "_fifo_count"},  32'(fifo_count),  32'h0);
    check({tag, "_in_ready"},    32'(in_ready),    32'h1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // tpu model: returns byte_of(read word) exactly LAT cycles after it appears, junk otherwise.
  always @(negedge clk) begin
    t_idx  = cyc % 8;
    result = tv[t_idx] ? tdat[t_idx] : 8'($urandom);
    tv[t_idx] = 1'b0;
    if (rst_n && instruction[15:14] == 2'b11) begin
      tv[(cyc + LAT) % 8]   = 1'b1;
      tdat[(cyc + LAT) % 8] = byte_of(instruction);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("fifo_count", 32'(fifo_count), 32'(mq.size()));
      check("in_ready",   32'(in_ready),   32'(mq.size() != DEPTH));
      check("issue_slot", 32'(instruction != 16'h0000), 32'(missue));
      if (instruction != 16'h0000) begin
        if (sb_instr.size() == 0) begin
          n_chk++;
          $display("FAIL instr_extra: got %0h with no word expected", instruction);
        end else begin
          check("instruction", 32'(instruction), 32'(sb_instr.pop_front()));
        end
      end
      if (res_valid) begin
        check("busy_at_res", 32'(busy), 32'h1);
        if (sb_res.size() == 0) begin
          n_chk++;
          $display("FAIL res_extra: got res_data %0h with no result expected", res_data);
        end else begin
          check("res_data", 32'(res_data), 32'(sb_res.pop_front()));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit, %0d/%0d done", n_pass, n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    clear_model();
    #3;
    check_reset_outputs("rst0");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fill past full, then run the 8 buffered words.
    for (int i = 1; i <= 9; i++) tick(1'b1, 16'h0100 + 16'(i), 1'b0);
    check("full_in_ready", 32'(in_ready), 32'h0);
    check("full_count",    32'(fifo_count), 32'd8);
    tick(1'b0, 16'h0000, 1'b1);
    wait_idle(100, 1'b0);
    check("fill_all_issued", 32'(sb_instr.size()), 32'h0);

    // Start on empty FIFO is ignored.
    tick(1'b0, 16'h0000, 1'b1);
    tick(1'b0, 16'h0000, 1'b0);
    check("empty_start_busy",  32'(busy),        32'h0);
    check("empty_start_instr", 32'(instruction), 32'h0);

    // Back-to-back reads.
    tick(1'b1, 16'h1234, 1'b0);
    tick(1'b1, 16'hC005, 1'b0);
    tick(1'b1, 16'hC006, 1'b0);
    tick(1'b0, 16'h0000, 1'b1);
    wait_idle(100, 1'b0);
    check("reads_returned", 32'(sb_res.size()), 32'h0);

    // Push on the first RUN cycle joins the same run.
    tick(1'b1, 16'h00A1, 1'b0);
    tick(1'b1, 16'h00A2, 1'b0);
    tick(1'b0, 16'h0000, 1'b1);
    tick(1'b1, 16'h0042, 1'b0);
    wait_idle(100, 1'b0);
    check("run_push_issued", 32'(sb_instr.size()), 32'h0);

    // Pointer wrap-around.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 6; i++) tick(1'b1, 16'h0200 + 16'(r * 16 + i), 1'b0);
      tick(1'b0, 16'h0000, 1'b1);
      wait_idle(100, 1'b0);
    end
    check("wrap_issued", 32'(sb_instr.size()), 32'h0);

    // Asynchronous reset mid-run.
    for (int i = 0; i < 5; i++) tick(1'b1, 16'hC010 + 16'(i), 1'b0);
    tick(1'b0, 16'h0000, 1'b1);
    tick(1'b0, 16'h0000, 1'b0);
    tick(1'b0, 16'h0000, 1'b0);
    tick(1'b0, 16'h0000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    clear_model();
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1'b0, 16'h0000, 1'b0);
    check("post_rst_busy", 32'(busy), 32'h0);

    // Randomized programs with pushes and ignored starts during runs.
    for (int it = 0; it < 40; it++) begin
      int n;
      n = $urandom_range(0, 14);
      for (int i = 0; i < n; i++) tick(1'($urandom_range(0, 1)), rnd_word(), 1'b0);
      tick(1'b0, 16'h0000, 1'b1);
      n = $urandom_range(0, 10);
      for (int j = 0; j < n; j++)
        tick(1'($urandom_range(0, 1)), rnd_word(), mrun ? 1'($urandom_range(0, 1)) : 1'b0);
      wait_idle(200, 1'b1);
    end

    // Flush leftover words so every scoreboard entry is consumed.
    tick(1'b0, 16'h0000, 1'b1);
    wait_idle(200, 1'b0);
    check("final_instr_sb", 32'(sb_instr.size()), 32'h0);
    check("final_res_sb",   32'(sb_res.size()),   32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tpu_cmd_issuer.md
Name: tpu_cmd_issuer

Overview:
- Host-side driver for the tpu 16-bit instruction port, and the collector of its 8-bit result port.
- Buffers instruction words pushed by a host over a valid/ready handshake, then issues them back-to-back on `start`.
- Emits NOP (16'h0000) whenever no instruction is being issued.
- Captures `result` a fixed latency after each read-type instruction and returns it to the host with a valid pulse.

Parameters:
- DEPTH, 8: instruction FIFO entries; power of two, minimum 2.
- READ_OPCODE, 2'b11: value of instruction[15:14] that marks a result-read instruction.
- READ_LAT, 2: cycles from a read instruction appearing on `instruction` to its byte being valid on `result`; minimum 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  host instruction word valid.
- in_ready  output  1  FIFO can accept a word (not full).
- in_instr  input  16  host instruction word.
- start  input  1  one-cycle pulse; begin issuing the buffered program.
- instruction  output  16  registered instruction to the tpu.
- result  input  8  tpu result byte.
- res_valid  output  1  one-cycle pulse; res_data holds a captured result.
- res_data  output  8  captured result byte.
- busy  output  1  high in RUN or DRAIN.
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values: state=IDLE, FIFO empty, fifo_count=0, in_ready=1, instruction=16'h0000, res_valid=0, res_data=0, busy=0, read-tracking shift register all zeros. Reset is honoured mid-operation; buffered words and pending reads are discarded.
- Push: occurs when in_valid && in_ready at the clock edge. in_ready = (fifo_count != DEPTH), combinational from registered count.
  - Pushes are allowed in any state, including RUN; words pushed during RUN are issued in the same run.
  - When full, in_valid is ignored and no data changes.
- FIFO: circular buffer with wrapping read/write pointers. Simultaneous push and pop leaves the count unchanged. Pop never occurs when empty.
- State machine:
  - IDLE: instruction=0. `start` with fifo_count>0 goes to RUN. `start` with an empty FIFO is ignored and stays in IDLE.
  - RUN: every cycle, pop the head word and register it onto `instruction` on the next edge (1-cycle latency from pop). When the FIFO becomes empty after a pop with no simultaneous push, go to DRAIN. `start` is ignored in RUN.
  - DRAIN: instruction=0. Stay until the read-tracking register is all zero, then go to IDLE. `start` is ignored in DRAIN.
- Read tracking: a shift register of READ_LAT bits.
  - Bit 0 is loaded with 1 on the cycle a word with [15:14]==READ_OPCODE is driven on `instruction`; 0 otherwise.
  - The register shifts every cycle.
  - When the MSB is 1: res_data <= result and res_valid=1 for exactly that one cycle.
  - Consecutive read instructions yield consecutive res_valid pulses, with no loss.
- busy = (state != IDLE).
- NOP insertion: `instruction` is 0 in every cycle not carrying a popped word, including the first cycle after `start` (pop cycle).

Test Plan:
- Reset: hold rst_n=0 asynchronously mid-cycle -> all outputs at reset values immediately; in_ready=1, fifo_count=0.
- Fill and full: push 9 words 16'h0101..16'h0109 with in_valid constant -> first 8 accepted, in_ready=0 after the 8th, fifo_count=8, 9th not stored. Pulse start -> instruction shows 0101..0108 on 8 consecutive cycles, then 0; busy falls once DRAIN completes.
- Empty start: start with FIFO empty -> state stays IDLE, busy=0, instruction=0.
- Read capture: program {16'h1234, 16'hC005, 16'hC006}, READ_LAT=2, tb drives result=8'hA5 then 8'h5A at the matching cycles -> res_valid pulses on two consecutive cycles with res_data 8'hA5 then 8'h5A; busy stays high until after the second pulse.
- Push during RUN: program of 2 words plus a push of 16'h0042 on the first RUN cycle -> 3 words issued contiguously, fifo_count never exceeds 2, no NOP gap.
- Wrap-around: push 6 words, run, push 6 more, run -> all 12 words issued in order; pointers wrap with correct data.
